// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined main-control unit: opcodes, bundle
// layouts and the stall FSM encoding.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int STALL_CNT_W = 3;

  typedef struct packed {
    logic [EX_W-1:0] ex;   // {RegDst, ALUOp[1:0], ALUSrc}
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '{ex: 4'b0000, m: 3'b000, wb: 2'b00};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } stall_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the EX/M/WB control bundles and a
// flag telling whether the opcode is one the datapath implements.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  output ctrl_bundle_t ctrl,
  output logic         legal
);

  // Opcode lookup; unknown opcodes decode to an all-zero bubble.
  always_comb begin
    ctrl  = CTRL_BUBBLE;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ctrl.ex              = 4'b1100;
        ctrl.wb[WB_REGWRITE] = 1'b1;
      end
      OP_LW: begin
        ctrl.ex              = 4'b0001;
        ctrl.m[M_MEMREAD]    = 1'b1;
        ctrl.wb[WB_REGWRITE] = 1'b1;
        ctrl.wb[WB_MEMTOREG] = 1'b1;
      end
      OP_SW: begin
        ctrl.ex              = 4'b0001;
        ctrl.m[M_MEMWRITE]   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.ex              = 4'b0010;
        ctrl.m[M_BRANCH]     = 1'b1;
      end
      OP_ADDI: begin
        ctrl.ex              = 4'b0001;
        ctrl.wb[WB_REGWRITE] = 1'b1;
      end
      OP_NOP: begin
        ctrl = CTRL_BUBBLE;
      end
      default: begin
        ctrl  = CTRL_BUBBLE;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined main control: decode in ID, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use stall FSM, branch flush and illegal-opcode tracking.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              branch_taken,
  output logic [EX_W-1:0]   idex_ex,
  output logic [M_W-1:0]    idex_m,
  output logic [WB_W-1:0]   idex_wb,
  output logic [M_W-1:0]    exmem_m,
  output logic [WB_W-1:0]   exmem_wb,
  output logic [WB_W-1:0]   memwb_wb,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(STALL_CYCLES - 1);
  // With a single bubble the IDLE-state hazard cycle is the whole stall.
  localparam logic MULTI_STALL = (STALL_CYCLES > 1) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_bundle_t             dec_s;
  logic                     dec_legal_s;
  logic                     hazard_s;
  logic                     stall_s;
  logic                     bubble_s;
  logic                     illegal_hit_s;

  ctrl_bundle_t             idex_q, idex_d;
  logic [REG_AW-1:0]        idex_rt_q, idex_rt_d;
  logic [M_W-1:0]           exmem_m_q, exmem_m_d;
  logic [WB_W-1:0]          exmem_wb_q, exmem_wb_d;
  logic [WB_W-1:0]          memwb_wb_q, memwb_wb_d;
  stall_state_t             state_q, state_d;
  logic [STALL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                     illegal_q, illegal_d;
  logic [CNT_W-1:0]         illegal_cnt_q, illegal_cnt_d;

  ctrl_decode u_decode (
    .opcode (id_opcode),
    .ctrl   (dec_s),
    .legal  (dec_legal_s)
  );

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    hazard_s = idex_q.m[M_MEMREAD] & id_valid & (idex_rt_q != {REG_AW{1'b0}}) &
               ((idex_rt_q == id_rs) | (idex_rt_q == id_rt));
  end

  // Stall FSM next state; a taken branch squashes any pending stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hazard_s && MULTI_STALL) begin
            state_d = ST_STALL;
            cnt_d   = STALL_RELOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end
        end
        ST_STALL: begin
          if (cnt_q <= 3'd1) begin
            if (hazard_s && MULTI_STALL) begin
              state_d = ST_STALL;
              cnt_d   = STALL_RELOAD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = 3'd0;
            end
          end else begin
            state_d = ST_STALL;
            cnt_d   = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // Stall FSM outputs.
  always_comb begin
    stall_s    = (state_q == ST_STALL) | ((state_q == ST_IDLE) & hazard_s);
    pc_write   = ~stall_s | branch_taken;
    ifid_write = ~stall_s | branch_taken;
  end

  // Control-register next values, bubble/flush insertion and illegal tracking.
  always_comb begin
    bubble_s      = ~id_valid | stall_s | branch_taken | ~dec_legal_s;
    illegal_hit_s = id_valid & ~dec_legal_s & ~stall_s & ~branch_taken;
    memwb_wb_d    = exmem_wb_q;
    if (branch_taken) begin
      exmem_m_d  = 3'b000;
      exmem_wb_d = 2'b00;
    end else begin
      exmem_m_d  = idex_q.m;
      exmem_wb_d = idex_q.wb;
    end
    if (bubble_s) begin
      idex_d    = CTRL_BUBBLE;
      idex_rt_d = {REG_AW{1'b0}};
    end else begin
      idex_d    = dec_s;
      idex_rt_d = id_rt;
    end
    illegal_d = illegal_q | illegal_hit_s;
    if (illegal_hit_s && (illegal_cnt_q != CNT_MAX)) begin
      illegal_cnt_d = illegal_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      illegal_cnt_d = illegal_cnt_q;
    end
  end

  // All state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q        <= CTRL_BUBBLE;
      idex_rt_q     <= {REG_AW{1'b0}};
      exmem_m_q     <= 3'b000;
      exmem_wb_q    <= 2'b00;
      memwb_wb_q    <= 2'b00;
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= {CNT_W{1'b0}};
    end else begin
      idex_q        <= idex_d;
      idex_rt_q     <= idex_rt_d;
      exmem_m_q     <= exmem_m_d;
      exmem_wb_q    <= exmem_wb_d;
      memwb_wb_q    <= memwb_wb_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign idex_ex     = idex_q.ex;
  assign idex_m      = idex_q.m;
  assign idex_wb     = idex_q.wb;
  assign exmem_m     = exmem_m_q;
  assign exmem_wb    = exmem_wb_q;
  assign memwb_wb    = memwb_wb_q;
  assign illegal_op  = illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances (1 and 3 bubbles per load-use) driven in
// lockstep and compared against a cycle-level reference of the control rules.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = 6'd0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       branch_taken = 1'b0;

  logic [3:0] o1_ex, o3_ex;
  logic [2:0] o1_m, o3_m, o1_exm, o3_exm;
  logic [1:0] o1_wb, o3_wb, o1_exwb, o3_exwb, o1_mwb, o3_mwb;
  logic       o1_pc, o3_pc, o1_ifw, o3_ifw, o1_ill, o3_ill;
  logic [7:0] o1_cnt, o3_cnt;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_AW(5), .STALL_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
    .idex_ex(o1_ex), .idex_m(o1_m), .idex_wb(o1_wb), .exmem_m(o1_exm),
    .exmem_wb(o1_exwb), .memwb_wb(o1_mwb), .pc_write(o1_pc), .ifid_write(o1_ifw),
    .illegal_op(o1_ill), .illegal_cnt(o1_cnt));

  ctrl_pipe #(.REG_AW(5), .STALL_CYCLES(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
    .idex_ex(o3_ex), .idex_m(o3_m), .idex_wb(o3_wb), .exmem_m(o3_exm),
    .exmem_wb(o3_exwb), .memwb_wb(o3_mwb), .pc_write(o3_pc), .ifid_write(o3_ifw),
    .illegal_op(o3_ill), .illegal_cnt(o3_cnt));

  int errs = 0;
  int checks = 0;

  // Reference state per instance: [0] -> 1 bubble, [1] -> 3 bubbles.
  int         nst [2] = '{1, 3};
  logic [8:0] m_idex [2];
  logic [4:0] m_rt [2];
  logic [2:0] m_exm [2];
  logic [1:0] m_exwb [2];
  logic [1:0] m_mwb [2];
  int         m_left [2];
  logic       m_ill [2];
  logic [7:0] m_cnt [2];
  logic       exp_pcw [2];
  logic       obs_pcw [2];
  logic       obs_ifw [2];

  // {legal, ex[3:0], m[2:0], wb[1:0]} straight from the decode table.
  function automatic logic [9:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b000000: return 10'b1_1100_000_10;
      6'b100011: return 10'b1_0001_010_11;
      6'b101011: return 10'b1_0001_001_00;
      6'b000100: return 10'b1_0010_100_00;
      6'b001000: return 10'b1_0001_000_10;
      6'b100000: return 10'b1_0000_000_00;
      default:   return 10'b0_0000_000_00;
    endcase
  endfunction

  function automatic logic [24:0] obs_vec(input int k);
    if (k == 0) return {o1_ex, o1_m, o1_wb, o1_exm, o1_exwb, o1_mwb, o1_ill, o1_cnt};
    else        return {o3_ex, o3_m, o3_wb, o3_exm, o3_exwb, o3_mwb, o3_ill, o3_cnt};
  endfunction

  function automatic logic [24:0] exp_vec(input int k);
    return {m_idex[k], m_exm[k], m_exwb[k], m_mwb[k], m_ill[k], m_cnt[k]};
  endfunction

  function automatic logic [8:0] obs_idex(input int k);
    if (k == 0) return {o1_ex, o1_m, o1_wb};
    else        return {o3_ex, o3_m, o3_wb};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idex[k] = 9'd0; m_rt[k] = 5'd0; m_exm[k] = 3'd0; m_exwb[k] = 2'd0;
      m_mwb[k] = 2'd0; m_left[k] = 0; m_ill[k] = 1'b0; m_cnt[k] = 8'd0;
    end
  endtask

  // One clock: drive inputs, sample pc/ifid writes, advance the reference.
  task automatic cyc(input logic v, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic br);
    logic [9:0] d;
    logic [2:0] mm;
    logic       hz, st, bub, hit;
    logic [8:0] n_idex [2];
    logic [4:0] n_rt [2];
    logic [2:0] n_exm [2];
    logic [1:0] n_exwb [2];
    logic [1:0] n_mwb [2];
    int         n_left [2];
    logic       n_ill [2];
    logic [7:0] n_cnt [2];
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; branch_taken = br;
    #1;
    d = ref_decode(op);
    for (int k = 0; k < 2; k++) begin
      mm  = m_idex[k][4:2];
      hz  = mm[1] && v && (m_rt[k] != 5'd0) && ((m_rt[k] == rs) || (m_rt[k] == rt));
      st  = (m_left[k] > 0) || hz;
      exp_pcw[k] = !st || br;
      obs_pcw[k] = (k == 0) ? o1_pc : o3_pc;
      obs_ifw[k] = (k == 0) ? o1_ifw : o3_ifw;
      bub = !v || st || br || !d[9];
      hit = v && !d[9] && !st && !br;
      n_mwb[k]  = m_exwb[k];
      n_exm[k]  = br ? 3'd0 : mm;
      n_exwb[k] = br ? 2'd0 : m_idex[k][1:0];
      n_idex[k] = bub ? 9'd0 : d[8:0];
      n_rt[k]   = bub ? 5'd0 : rt;
      if (br) n_left[k] = 0;
      else if (m_left[k] == 0) n_left[k] = hz ? nst[k] - 1 : 0;
      else n_left[k] = (m_left[k] == 1 && hz) ? nst[k] - 1 : m_left[k] - 1;
      n_ill[k] = m_ill[k] | hit;
      n_cnt[k] = (hit && m_cnt[k] != 8'hFF) ? m_cnt[k] + 8'd1 : m_cnt[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_idex[k] = n_idex[k]; m_rt[k] = n_rt[k]; m_exm[k] = n_exm[k];
      m_exwb[k] = n_exwb[k]; m_mwb[k] = n_mwb[k]; m_left[k] = n_left[k];
      m_ill[k] = n_ill[k]; m_cnt[k] = n_cnt[k];
    end
    #1;
  endtask

  task automatic do_reset();
    id_valid = 1'b0; branch_taken = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== 25'd0) begin
        errs++; $display("FAIL reset_state[%0d]: got %h expected %h", k, obs_vec(k), 25'd0);
      end
    end
    checks++;
    if ({o1_pc, o1_ifw, o3_pc, o3_ifw} !== 4'b1111) begin
      errs++; $display("FAIL reset_pcw: got %b expected 1111", {o1_pc, o1_ifw, o3_pc, o3_ifw});
    end
  endtask

  task automatic test_rtype();
    do_reset();
    cyc(1'b1, 6'b000000, 5'd1, 5'd2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_idex(k) !== 9'b1100_000_10 || obs_pcw[k] !== 1'b1) begin
        errs++; $display("FAIL rtype_idex[%0d]: got %b/%b expected 110000010/1", k, obs_idex(k), obs_pcw[k]);
      end
    end
    cyc(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++;
    if ({o1_exwb, o3_exwb} !== 4'b1010) begin
      errs++; $display("FAIL rtype_exmem_wb: got %b expected 1010", {o1_exwb, o3_exwb});
    end
    cyc(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++;
    if ({o1_mwb, o3_mwb} !== 4'b1010 || {o1_pc, o3_pc} !== 2'b11) begin
      errs++; $display("FAIL rtype_memwb_wb: got %b pc %b expected 1010 pc 11", {o1_mwb, o3_mwb}, {o1_pc, o3_pc});
    end
  endtask

  task automatic test_load_use();
    int stalls [2];
    do_reset();
    cyc(1'b1, 6'b100011, 5'd1, 5'd5, 1'b0);
    stalls = '{0, 0};
    for (int c = 1; c <= 5; c++) begin
      cyc(1'b1, 6'b000000, 5'd5, 5'd2, 1'b0);
      for (int k = 0; k < 2; k++) begin
        if (obs_pcw[k] === 1'b0) stalls[k]++;
        checks++;
        if (obs_pcw[k] !== exp_pcw[k] || obs_ifw[k] !== exp_pcw[k] || obs_vec(k) !== exp_vec(k)) begin
          errs++; $display("FAIL load_use_cycle%0d[%0d]: got pc %b if %b st %h expected pc %b st %h",
                           c, k, obs_pcw[k], obs_ifw[k], obs_vec(k), exp_pcw[k], exp_vec(k));
        end
        if (c == nst[k] + 1) begin
          checks++;
          if (obs_idex(k) !== 9'b1100_000_10) begin
            errs++; $display("FAIL load_use_resume[%0d]: got %b expected 110000010", k, obs_idex(k));
          end
        end else if (c <= nst[k]) begin
          checks++;
          if (obs_idex(k) !== 9'd0 || obs_pcw[k] !== 1'b0) begin
            errs++; $display("FAIL load_use_bubble[%0d]: got %b pc %b expected 0 pc 0", k, obs_idex(k), obs_pcw[k]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stalls[k] != nst[k]) begin
        errs++; $display("FAIL load_use_count[%0d]: got %0d expected %0d", k, stalls[k], nst[k]);
      end
    end
  endtask

  task automatic test_rt_zero();
    do_reset();
    cyc(1'b1, 6'b100011, 5'd3, 5'd0, 1'b0);
    cyc(1'b1, 6'b000000, 5'd0, 5'd4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_pcw[k] !== 1'b1 || obs_idex(k) !== 9'b1100_000_10) begin
        errs++; $display("FAIL rt_zero[%0d]: got pc %b idex %b expected pc 1 idex 110000010", k, obs_pcw[k], obs_idex(k));
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    cyc(1'b1, 6'b100011, 5'd1, 5'd5, 1'b0);
    cyc(1'b1, 6'b000000, 5'd5, 5'd2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_pcw[k] !== 1'b1 || obs_vec(k) !== 25'd0) begin
        errs++; $display("FAIL branch_flush[%0d]: got pc %b st %h expected pc 1 st 0", k, obs_pcw[k], obs_vec(k));
      end
    end
    cyc(1'b1, 6'b000000, 5'd5, 5'd2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_pcw[k] !== 1'b1 || obs_idex(k) !== 9'b1100_000_10) begin
        errs++; $display("FAIL branch_idle[%0d]: got pc %b idex %b expected pc 1 idex 110000010", k, obs_pcw[k], obs_idex(k));
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 6'b111111, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k) || obs_idex(k) !== 9'd0 || obs_vec(k)[8] !== 1'b1) begin
          errs++; $display("FAIL illegal_op%0d[%0d]: got %h expected %h", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (o1_cnt !== 8'd255 || o3_cnt !== 8'd255) begin
      errs++; $display("FAIL illegal_sat: got %0d/%0d expected 255", o1_cnt, o3_cnt);
    end
  endtask

  task automatic test_random();
    logic [5:0] pool [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                             6'b001000, 6'b100000, 6'b111111, 6'b000010};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1 ^ ($urandom_range(0, 9) == 0), pool[$urandom_range(0, 7)],
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_pcw[k] !== exp_pcw[k] || obs_ifw[k] !== exp_pcw[k] || obs_vec(k) !== exp_vec(k)) begin
          errs++; $display("FAIL random%0d[%0d]: got pc %b st %h expected pc %b st %h",
                           i, k, obs_pcw[k], obs_vec(k), exp_pcw[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    cyc(1'b1, 6'b100011, 5'd1, 5'd5, 1'b0);
    cyc(1'b1, 6'b000000, 5'd5, 5'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== 25'd0) begin
        errs++; $display("FAIL mid_stall_reset[%0d]: got %h expected 0", k, obs_vec(k));
      end
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    cyc(1'b1, 6'b000000, 5'd5, 5'd2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_pcw[k] !== 1'b1 || obs_vec(k) !== exp_vec(k)) begin
        errs++; $display("FAIL post_reset_pc[%0d]: got pc %b st %h expected pc 1 st %h", k, obs_pcw[k], obs_vec(k), exp_vec(k));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rtype();
    test_load_use();
    test_rt_zero();
    test_branch();
    test_illegal();
    test_random();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the combinational main control decoder of the five-stage MIPS datapath.
- Decodes the ID-stage opcode into EX/M/WB control bundles, then carries them through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts a parametrised number of bubbles, applies branch flushes, and flags and counts unrecognised opcodes.

Parameters:
REG_AW, 5, register-specifier width (rs/rt).
STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
CNT_W, 8, width of saturating illegal-opcode counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
id_valid  in  1  IF/ID holds a real instruction.
id_opcode  in  6  opcode in ID.
id_rs  in  REG_AW  rs specifier in ID.
id_rt  in  REG_AW  rt specifier in ID.
branch_taken  in  1  resolved taken branch from EX/MEM (Branch & zero).
idex_ex  out  4  ID/EX EX bundle {RegDst, ALUOp[1:0], ALUSrc}.
idex_m  out  3  ID/EX M bundle {Branch, MemRead, MemWrite}.
idex_wb  out  2  ID/EX WB bundle {RegWrite, MemToReg}.
exmem_m  out  3  EX/MEM M bundle.
exmem_wb  out  2  EX/MEM WB bundle.
memwb_wb  out  2  MEM/WB WB bundle.
pc_write  out  1  PC update enable (0 during stall).
ifid_write  out  1  IF/ID update enable (0 during stall).
illegal_op  out  1  sticky: an unrecognised opcode was decoded.
illegal_cnt  out  CNT_W  saturating count of unrecognised opcodes.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: while rst_n=0, every control register, the stall counter, illegal_op and illegal_cnt are 0. After release, pc_write=1 and ifid_write=1.
- Decode table (EX/M/WB). All don't-cares resolve to 0.
  - RTYPE 000000: 1100/000/10.
  - LW 100011: 0001/010/11.
  - SW 101011: 0001/001/00.
  - BEQ 000100: 0010/100/00.
  - ADDI 001000: 0001/000/10.
  - NOP 100000: 0000/000/00.
  - Any other opcode: bubble (all zero).
- Pipeline registers update every cycle (no enable) in this order:
  - memwb_wb <= exmem_wb.
  - exmem_m/exmem_wb <= idex_m/idex_wb.
  - idex_* <= decoded bundles.
  - Decode-to-idex latency is 1 cycle. Decode-to-memwb latency is 3 cycles.
- Bubble into ID/EX (all zero) when any of these holds: id_valid=0, stall active, branch_taken, or opcode unrecognised.
- Hazard detect (combinational): hazard = idex_m[1] & id_valid & ((idex_wb-dest rt == id_rs) | (== id_rt)) & (rt != 0).
  - Destination rt is tracked in an internal idex_rt register, loaded with id_rt whenever ID/EX loads a real instruction. It is zeroed on bubble.
- Stall FSM:
  - IDLE→STALL on hazard & !branch_taken. The counter loads STALL_CYCLES-1.
  - In STALL, the counter decrements each cycle and the FSM returns to IDLE when it reaches 0 and it is decremented.
  - stall = hazard (in IDLE) or state==STALL. A hazard therefore yields exactly STALL_CYCLES stalled cycles.
  - A new hazard on the last STALL cycle re-arms the FSM.
- pc_write = ifid_write = !stall | branch_taken.
- Flush: branch_taken takes priority over stall.
  - ID/EX and EX/MEM both load zero.
  - FSM forced to IDLE with counter 0.
  - memwb_wb still advances normally.
- Illegal: id_valid & unrecognised opcode & !stall & !branch_taken sets illegal_op (sticky until reset) and increments illegal_cnt. illegal_cnt saturates at all-ones.
- Reset asserted mid-stall: FSM returns to IDLE immediately. No residual stall after release.

Decomposition:
- Shared package ctrl_pkg holds:
  - Opcode constants: RTYPE, LW, SW, BEQ, ADDI, NOP.
  - Bundle widths: EX_W=4, M_W=3, WB_W=2.
  - Bit-index constants: M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0, WB_REGWRITE=1, WB_MEMTOREG=0.
  - Bundle struct typedefs.
- One sub-module: ctrl_decode, a purely combinational opcode→{ex,m,wb,legal} table.
- Registers, hazard unit and stall FSM stay in ctrl_pipe.

Test Plan:
- Reset then RTYPE with id_valid=1:
  - idex = 1100/000/10 next cycle.
  - exmem_wb = 10 one cycle later.
  - memwb_wb = 10 after three edges.
  - pc_write=1 throughout.
- LW rt=5, then ADD rs=5, STALL_CYCLES=1:
  - pc_write=ifid_write=0 for exactly 1 cycle.
  - idex all-zero that cycle.
  - ADD decoded on the next cycle.
- Same sequence with STALL_CYCLES=3:
  - Three consecutive stall cycles and three zero bubbles.
- LW rt=0, then ADD rs=0: no stall.
- Hazard coincident with branch_taken=1:
  - No stall; pc_write=1.
  - idex and exmem zeroed.
  - FSM IDLE next cycle.
- 300 illegal opcodes (e.g. 111111) with CNT_W=8:
  - illegal_op=1 after the first.
  - illegal_cnt saturates at 255.
  - idex all-zero for each.
- Reset asserted mid-stall:
  - All outputs zero immediately.
  - pc_write=1 after release.
